mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one multi-cycle memory backend (stallmem-style Rd/Wr/Stall/Done/Err) between the
//   instruction-fetch port (read-only) and the data-memory port (read/write) of the pipeline.
//   Sits between fetch/memory stages and the single unified memory. Serialises accesses and
//   gives the data port priority, with a starvation bound for fetch.
//   Returns per-port stall/done/data/err so each stage can freeze while its access is pending.
// PARAMETERS
//   ADDR_W        16  address width
//   DATA_W        16  data width
//   MAX_DM_STREAK 4   consecutive data grants allowed while fetch waits; then fetch is forced
// PORTS
//   clk          in   1       clock; all state updates on rising edge
//   rst          in   1       reset, synchronous, active-low (0 = reset)
//   if_req       in   1       fetch read request; held until if_done
//   if_addr      in   ADDR_W  fetch address
//   if_rdata     out  DATA_W  fetch read data; valid with if_done, held until next if_done
//   if_stall     out  1       if_req & ~if_done (combinational)
//   if_done      out  1       one-cycle completion pulse for fetch
//   if_err       out  1       error flag, valid with if_done
//   dm_rd        in   1       data read request; held until dm_done
//   dm_wr        in   1       data write request; held until dm_done
//   dm_addr      in   ADDR_W  data address
//   dm_wdata     in   DATA_W  write data
//   dm_rdata     out  DATA_W  data read result; valid with dm_done, held until next dm_done
//   dm_stall     out  1       (dm_rd|dm_wr) & ~dm_done (combinational)
//   dm_done      out  1       one-cycle completion pulse for data port
//   dm_err       out  1       error flag, valid with dm_done
//   mem_rd/mem_wr out 1       backend strobes; asserted for exactly one cycle per access
//   mem_addr     out  ADDR_W  backend address (registered, stable ISSUE..WAIT)
//   mem_wdata    out  DATA_W  backend write data (registered)
//   mem_rdata    in   DATA_W  backend read data, valid when mem_done
//   mem_done     in   1       backend completion; mem_err in 1 backend error (valid with done)
// BEHAVIOUR
//   - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE. ISSUE->RESP directly if mem_done in ISSUE.
//   - IDLE: pick winner, latch port id/addr/wdata/op. No request -> stay IDLE.
//   - ISSUE: mem_rd or mem_wr = 1 for this single cycle. WAIT: strobes 0, wait mem_done.
//   - RESP: port_done=1 one cycle, rdata/err registered from backend; then IDLE.
//   - Latency: request seen cycle 0 -> done cycle 2 at best; max throughput 1 access / 3 cycles.
//   - Arbitration in IDLE: data port wins if active, unless streak==MAX_DM_STREAK and if_req=1.
//   - Streak counter: +1 on data grant with if_req=1 (saturates); cleared on fetch grant or
//     on data grant with if_req=0.
//   - dm_rd & dm_wr both 1: performed as write, dm_err=1 with dm_done.
//   - Requests sampled only in IDLE; changes during ISSUE/WAIT/RESP ignored.
//   - Requester deasserts or changes request the cycle after done; RESP->IDLE prevents reissue.
//   - Reset (rst=0, any state incl. mid-access): state IDLE, all outputs 0, rdata regs 0,
//     streak 0; strobes low the next cycle. Any in-flight backend result is discarded.
// CONFIGURATION
//   MEM_ARB_ALIGN_CHECK_EN defined: odd address (addr[0]=1) on either port is not issued;
//     IDLE -> RESP directly, port_err=1, rdata unchanged, no backend strobe.
//   Not defined: address passed through unchecked; alignment errors come only via mem_err.
// STRUCTURE
//   Package mem_arb_pkg: FSM state encodings (IDLE/ISSUE/WAIT/RESP), port id constants
//     (PORT_IF=0, PORT_DM=1), op encodings.
//   Sub-module mem_arb_streak_ctr: saturating streak counter with force_if output.
// TESTING
//   1 Fetch alone, addr 0x0010, mem_done in ISSUE -> mem_rd 1 cycle, if_done at cycle 2, rdata 0xBEEF.
//   2 Both request at cycle 0 -> dm served first, if_stall=1 until its own if_done later.
//   3 dm + if requesting continuously -> after 4 data grants, 5th grant goes to fetch; streak 0 after.
//   4 dm_wr 0x0042 <- 0x1234, mem_done 5 cycles later -> dm_done once, then dm_rd 0x0042 returns 0x1234.
//   5 rst=0 during WAIT -> next cycle IDLE, no done pulse, strobes 0; late mem_done ignored.
//   6 ALIGN_CHECK_EN, dm_rd addr 0x0003 -> no mem_rd, dm_done+dm_err at cycle 1; undefined: issued.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory-port arbiter: FSM states, port ids, access ops.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arbState_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } memOp_t;

endpackage

// File: rtl/mem_arb_streak_ctr.sv
// Counts back-to-back data grants taken while fetch waits; forceIf hands the next grant to fetch.
// Updates only on a grant cycle; saturates at MAX_STREAK.
module mem_arb_streak_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic grantVld,
  input  logic grantPort,
  input  logic ifReq,
  output logic forceIf
);
  localparam int CW = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;

  logic [CW-1:0] streak;

  always_ff @(posedge clk) begin
    if (!rst) begin
      streak <= '0;
    end else if (grantVld) begin
      if (grantPort == PORT_DM && ifReq) begin
        if (streak != CW'(MAX_STREAK)) streak <= streak + CW'(1);
      end else begin
        streak <= '0;
      end
    end
  end

  assign forceIf = (streak == CW'(MAX_STREAK));

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data-port accesses onto one multi-cycle memory; data wins unless fetch is starved.
// Best case done two cycles after the request; ports stall until done. MEM_ARB_ALIGN_CHECK_EN rejects odd addresses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  output logic              if_done,
  output logic              if_err,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              dm_done,
  output logic              dm_err,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  input  logic              mem_err
);
  arbState_t         state;
  logic              curPort;
  memOp_t            curOp;
  logic              dualOp;
  logic              dmActive;
  logic              dmWins;
  logic              forceIf;
  logic              grantVld;
  logic              grantPort;
  logic [ADDR_W-1:0] grantAddr;
  logic              addrBad;

  assign dmActive  = dm_rd | dm_wr;
  assign dmWins    = dmActive & ~(forceIf & if_req);
  assign grantVld  = (state == IDLE) & (dmActive | if_req);
  assign grantPort = dmWins ? PORT_DM : PORT_IF;
  assign grantAddr = dmWins ? dm_addr : if_addr;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign addrBad = grantAddr[0];
`else
  assign addrBad = 1'b0;
`endif

  mem_arb_streak_ctr #(.MAX_STREAK(MAX_DM_STREAK)) streakCtr (
    .clk      (clk),
    .rst      (rst),
    .grantVld (grantVld),
    .grantPort(grantPort),
    .ifReq    (if_req),
    .forceIf  (forceIf)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      curPort   <= PORT_IF;
      curOp     <= OP_RD;
      dualOp    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      dm_done   <= 1'b0;
      dm_err    <= 1'b0;
      dm_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantVld) begin
            curPort  <= grantPort;
            // Simultaneous rd+wr is carried out as a write and flagged at completion.
            curOp    <= (dmWins && dm_wr) ? OP_WR : OP_RD;
            dualOp   <= dmWins & dm_rd & dm_wr;
            mem_addr <= grantAddr;
            if (dmWins) mem_wdata <= dm_wdata;
            if (addrBad) begin
              state <= RESP;
              if (dmWins) begin
                dm_done <= 1'b1;
                dm_err  <= 1'b1;
              end else begin
                if_done <= 1'b1;
                if_err  <= 1'b1;
              end
            end else begin
              state  <= ISSUE;
              mem_wr <= dmWins & dm_wr;
              mem_rd <= ~(dmWins & dm_wr);
            end
          end
        end
        ISSUE, WAIT: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          if (mem_done) begin
            state <= RESP;
            if (curPort == PORT_DM) begin
              dm_done <= 1'b1;
              dm_err  <= mem_err | dualOp;
              if (curOp == OP_RD) dm_rdata <= mem_rdata;
            end else begin
              if_done  <= 1'b1;
              if_err   <= mem_err;
              if_rdata <= mem_rdata;
            end
          end else begin
            state <= WAIT;
          end
        end
        RESP: begin
          // One dead cycle so a request still held during the done pulse is not reissued.
          state   <= IDLE;
          if_done <= 1'b0;
          if_err  <= 1'b0;
          dm_done <= 1'b0;
          dm_err  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dmActive & ~dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: timeline model of grants/completions checked every cycle plus literal spot checks.
module tb_mem_port_arbiter;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_stall, if_done, if_err;
  logic [15:0] if_addr, if_rdata;
  logic        dm_rd, dm_wr, dm_stall, dm_done, dm_err;
  logic [15:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_rd, mem_wr, mem_done, mem_err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_DM_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
    .if_done(if_done), .if_err(if_err),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_stall(dm_stall), .dm_done(dm_done), .dm_err(dm_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    nVec = 0;
  int    nMis = 0;
  int    memLat = 0;
  int    nStrobe = 0;
  string ord = "";

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Backend memory: latency memLat cycles after the strobe (0 = same cycle); odd addresses report mem_err.
  logic [15:0] memArr [0:65535];
  logic [15:0] beAddr;
  bit          beRd, bePend = 0, fire;
  int          beCnt;

  always @(negedge clk) begin
    fire = 0;
    mem_done = 1'b0;
    mem_err  = 1'b0;
    if (bePend) begin
      if (beCnt == 0) begin fire = 1; bePend = 0; end
      else beCnt--;
    end
    if (mem_rd || mem_wr) begin
      nStrobe++;
      beAddr = mem_addr;
      beRd   = mem_rd;
      if (mem_wr) memArr[mem_addr] = mem_wdata;
      if (memLat == 0) fire = 1;
      else begin bePend = 1; beCnt = memLat - 1; end
    end
    if (fire) begin
      mem_done  = 1'b1;
      mem_err   = beAddr[0];
      mem_rdata = beRd ? memArr[beAddr] : 16'h0000;
    end
  end

  // Reference model: a grant in an idle cycle c strobes at c+1 and completes at c+2+latency;
  // the arbiter is free again the cycle after completion.
  logic [15:0] refMem [0:65535];
  bit          txnAct = 0, tPortDm, tWr, tIssued, tUpd, tErr, alignBad, rstPrev = 0;
  bit          eIfD, eDmD, eRd, eWr;
  int          tIssue, tDone, freeAt = 0, streak = 0;
  logic [15:0] tAddr, tWdata, tRdata, expIfR, expDmR;

  always @(negedge clk) begin
    if (!rstPrev) begin
      txnAct = 0; freeAt = cyc; streak = 0; expIfR = 16'h0; expDmR = 16'h0;
    end
    eIfD = txnAct && cyc == tDone && !tPortDm;
    eDmD = txnAct && cyc == tDone && tPortDm;
    eRd  = txnAct && tIssued && cyc == tIssue && !tWr;
    eWr  = txnAct && tIssued && cyc == tIssue && tWr;
    if (txnAct && cyc == tDone && tUpd) begin
      if (tPortDm) expDmR = tRdata; else expIfR = tRdata;
    end
    chk("if_done", {31'd0, if_done}, {31'd0, eIfD});
    chk("dm_done", {31'd0, dm_done}, {31'd0, eDmD});
    chk("mem_rd", {31'd0, mem_rd}, {31'd0, eRd});
    chk("mem_wr", {31'd0, mem_wr}, {31'd0, eWr});
    chk("if_rdata", {16'd0, if_rdata}, {16'd0, expIfR});
    chk("dm_rdata", {16'd0, dm_rdata}, {16'd0, expDmR});
    chk("if_stall", {31'd0, if_stall}, {31'd0, if_req & ~eIfD});
    chk("dm_stall", {31'd0, dm_stall}, {31'd0, (dm_rd | dm_wr) & ~eDmD});
    if (eIfD) chk("if_err", {31'd0, if_err}, {31'd0, tErr});
    if (eDmD) chk("dm_err", {31'd0, dm_err}, {31'd0, tErr});
    if (eRd || eWr) chk("mem_addr", {16'd0, mem_addr}, {16'd0, tAddr});
    if (eWr) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, tWdata});
    if (txnAct && cyc == tDone) txnAct = 0;

    if (rst && !txnAct && cyc >= freeAt && (if_req || dm_rd || dm_wr)) begin
      tPortDm = (dm_rd || dm_wr) && !(streak >= MAXS && if_req);
      if (tPortDm && if_req) streak = (streak < MAXS) ? streak + 1 : MAXS;
      else streak = 0;
      tWr    = tPortDm && dm_wr;
      tAddr  = tPortDm ? dm_addr : if_addr;
      tWdata = dm_wdata;
      tErr   = tPortDm && dm_rd && dm_wr;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      alignBad = tAddr[0];
`else
      alignBad = 1'b0;
`endif
      if (alignBad) begin
        tIssued = 0; tDone = cyc + 1; tErr = 1; tUpd = 0;
      end else begin
        tIssued = 1; tIssue = cyc + 1; tDone = cyc + 2 + memLat;
        tErr   = tErr | tAddr[0];
        tUpd   = !tWr;
        tRdata = refMem[tAddr];
        if (tWr) refMem[tAddr] = tWdata;
      end
      txnAct = 1;
      freeAt = tDone + 1;
    end
    rstPrev = rst;
  end

  task automatic ifAccess(input logic [15:0] a, output int lat, output logic [15:0] rd, output logic er);
    int s;
    bit got;
    if_req = 1'b1; if_addr = a; s = cyc; got = 0; lat = -1; rd = 16'h0; er = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (if_done) begin got = 1; lat = cyc - s; rd = if_rdata; er = if_err; ord = {ord, "F"}; end
    end
    if (!got) begin
      nVec++; nMis++;
      $display("FAIL if_timeout addr=%h got=no_done want=if_done", a);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic dmAccess(input logic r, input logic w, input logic [15:0] a, input logic [15:0] wd,
                          output int lat, output logic [15:0] rd, output logic er);
    int s;
    bit got;
    dm_rd = r; dm_wr = w; dm_addr = a; dm_wdata = wd; s = cyc; got = 0; lat = -1; rd = 16'h0; er = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (dm_done) begin got = 1; lat = cyc - s; rd = dm_rdata; er = dm_err; ord = {ord, "D"}; end
    end
    if (!got) begin
      nVec++; nMis++;
      $display("FAIL dm_timeout addr=%h got=no_done want=dm_done", a);
    end
    @(posedge clk); #1;
    dm_rd = 1'b0; dm_wr = 1'b0;
  endtask

  initial begin
    int          lat, lat2, s0, nd;
    logic [15:0] rd, rd2;
    logic        er, er2;
    for (int i = 0; i < 65536; i++) begin
      memArr[i] = 16'(i) ^ 16'hA5A5;
      refMem[i] = 16'(i) ^ 16'hA5A5;
    end
    memArr[16'h0010] = 16'hBEEF;
    refMem[16'h0010] = 16'hBEEF;
    rst = 1'b0; if_req = 1'b0; if_addr = 16'h0;
    dm_rd = 1'b0; dm_wr = 1'b0; dm_addr = 16'h0; dm_wdata = 16'h0;
    mem_done = 1'b0; mem_err = 1'b0; mem_rdata = 16'h0;

    repeat (3) @(posedge clk); #1;
    chk("rst_outputs", {if_done, dm_done, mem_rd, mem_wr, if_err, dm_err}, 32'd0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Fetch alone, backend answers during the issue cycle.
    s0 = nStrobe;
    ifAccess(16'h0010, lat, rd, er);
    chk("t1_lat", lat, 2);
    chk("t1_rdata", {16'd0, rd}, 32'h0000BEEF);
    chk("t1_err", {31'd0, er}, 32'd0);
    chk("t1_strobes", nStrobe - s0, 1);

    // Both ports request together: data first, fetch three cycles later.
    fork
      ifAccess(16'h0020, lat, rd, er);
      dmAccess(1'b1, 1'b0, 16'h0030, 16'h0, lat2, rd2, er2);
    join
    chk("t2_dm_lat", lat2, 2);
    chk("t2_if_lat", lat, 5);
    chk("t2_dm_rdata", {16'd0, rd2}, 32'h0000A595);
    chk("t2_if_rdata", {16'd0, rd}, 32'h0000A585);

    // Continuous contention: four data grants, then fetch is forced through.
    ord = "";
    fork
      begin
        for (int i = 0; i < 9; i++) dmAccess(1'b1, 1'b0, 16'(16'h0100 + 2 * i), 16'h0, lat2, rd2, er2);
      end
      begin
        for (int i = 0; i < 2; i++) ifAccess(16'(16'h0200 + 2 * i), lat, rd, er);
      end
    join
    nVec++;
    if (ord != "DDDDFDDDDFD") begin
      nMis++;
      $display("FAIL t3_order got=%s want=DDDDFDDDDFD", ord);
    end

    // Slow write then read-back.
    memLat = 5;
    s0 = nStrobe;
    dmAccess(1'b0, 1'b1, 16'h0042, 16'h1234, lat, rd, er);
    chk("t4_wr_lat", lat, 7);
    chk("t4_wr_err", {31'd0, er}, 32'd0);
    chk("t4_wr_strobes", nStrobe - s0, 1);
    memLat = 0;
    dmAccess(1'b1, 1'b0, 16'h0042, 16'h0, lat, rd, er);
    chk("t4_rd_data", {16'd0, rd}, 32'h00001234);
    chk("t4_rd_lat", lat, 2);

    // Read and write asserted together: write happens, error flagged.
    dmAccess(1'b1, 1'b1, 16'h0050, 16'h5A5A, lat, rd, er);
    chk("dual_err", {31'd0, er}, 32'd1);
    dmAccess(1'b1, 1'b0, 16'h0050, 16'h0, lat, rd, er);
    chk("dual_rdback", {16'd0, rd}, 32'h00005A5A);
    chk("dual_rd_err", {31'd0, er}, 32'd0);

    // Reset while waiting on a slow backend; the late mem_done must be ignored.
    memLat = 5;
    dm_rd = 1'b1; dm_addr = 16'h0060;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0; dm_rd = 1'b0;
    @(posedge clk); #1;
    chk("t5_strobe", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("t5_done", {30'd0, dm_done, if_done}, 32'd0);
    chk("t5_rdata", {if_rdata, dm_rdata}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (dm_done || if_done) nd++;
    end
    chk("t5_no_done", nd, 0);
    @(posedge clk); #1;
    memLat = 0;
    dmAccess(1'b1, 1'b0, 16'h0042, 16'h0, lat, rd, er);
    chk("t5_after_rd", {16'd0, rd}, 32'h00001234);

    // Odd addresses.
    s0 = nStrobe;
    dmAccess(1'b1, 1'b0, 16'h0003, 16'h0, lat, rd, er);
    chk("t6_dm_err", {31'd0, er}, 32'd1);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    chk("t6_dm_lat", lat, 1);
    chk("t6_dm_strobes", nStrobe - s0, 0);
    chk("t6_dm_rdata", {16'd0, rd}, 32'h00001234);
`else
    chk("t6_dm_lat", lat, 2);
    chk("t6_dm_strobes", nStrobe - s0, 1);
    chk("t6_dm_rdata", {16'd0, rd}, 32'h0000A5A6);
`endif
    ifAccess(16'h0011, lat, rd, er);
    chk("t6_if_err", {31'd0, er}, 32'd1);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    chk("t6_if_lat", lat, 1);
`else
    chk("t6_if_lat", lat, 2);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #100000;
    nMis++;
    $display("FAIL watchdog got=running want=finished");
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $fatal(1, "watchdog expired");
  end

endmodule
